// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor BHT.
package bp_pkg;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Helpers work on a wide container; callers truncate to their CTR_WIDTH.
  localparam int CTR_MAX_W = 16;
  typedef logic [CTR_MAX_W-1:0] ctr_t;

  // Weakly not-taken: one below the taken threshold.
  function automatic ctr_t ctr_init(input int ctr_width);
    return ctr_t'((1 << (ctr_width - 1)) - 1);
  endfunction

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken, input int ctr_width);
    ctr_t max_val;
    max_val = ctr_t'((1 << ctr_width) - 1);
    if (taken) return (ctr == max_val) ? ctr : ctr + ctr_t'(1);
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Counter storage: one combinational read port, one clocked write port.
// A same-cycle read of the written entry returns the old value.
module bp_sat_counter_table #(
  parameter int ENTRIES   = 32,
  parameter int CTR_WIDTH = 2,
  parameter int IDX_W     = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic [IDX_W-1:0]     raddr,
  output logic [CTR_WIDTH-1:0] rdata,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [CTR_WIDTH-1:0] wdata
);

  logic [CTR_WIDTH-1:0] mem [ENTRIES];

  // NOTE: the array has no reset; the top's sweep initialises every entry instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: PC-indexed bimodal table, or gshare when
// BHT_GSHARE_EN is defined. Holds the init sweep FSM, IF->X register and stats.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRIES   = 32,
  parameter int CTR_WIDTH = 2,
  parameter int GHR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] if_pc,
  input  logic                if_is_br,
  output logic                br_pred_taken,
  input  logic                x_br_taken,
  output logic                ready,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_init(CTR_WIDTH));

  bp_state_e            state;
  logic [IDX_W-1:0]     sweep_idx;
  logic                 x_valid;
  logic [IDX_W-1:0]     x_idx;
  logic                 x_pred;
  logic [CTR_WIDTH-1:0] x_ctr;
  logic [IDX_W-1:0]     pc_idx;
  logic [IDX_W-1:0]     lookup_idx;
  logic [CTR_WIDTH-1:0] rdata;
  logic [CTR_WIDTH-1:0] ctr_next;
  logic                 upd;
  logic                 we;
  logic [IDX_W-1:0]     waddr;
  logic [CTR_WIDTH-1:0] wdata;
  logic                 unused_pc;

  assign pc_idx    = if_pc[IDX_W+1:2];
  assign unused_pc = ^{if_pc[PC_WIDTH-1:IDX_W+2], if_pc[1:0]};
  assign ready     = (state == BP_RUN);
  assign upd       = x_valid & ~stall & ready;
  assign ctr_next  = CTR_WIDTH'(sat_update(ctr_t'(x_ctr), x_br_taken, CTR_WIDTH));

`ifdef BHT_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr;

  always_ff @(posedge clk) begin
    if (rst)      ghr <= '0;
    else if (upd) ghr <= GHR_WIDTH'({ghr, x_br_taken});
  end

  assign lookup_idx = pc_idx ^ IDX_W'(ghr);
`else
  // Bimodal: history is permanently zero, so the index is the PC alone.
  localparam logic [GHR_WIDTH-1:0] GHR_NONE = '0;
  assign lookup_idx = pc_idx ^ IDX_W'(GHR_NONE);
`endif

  assign br_pred_taken = rdata[CTR_WIDTH-1] & if_is_br & ready;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    we    = 1'b0;
    waddr = x_idx;
    wdata = ctr_next;
    if (state == BP_INIT) begin
      we    = 1'b1;
      waddr = sweep_idx;
      wdata = CTR_INIT;
    end else if (upd) begin
      we = 1'b1;
    end
  end

  bp_sat_counter_table #(
    .ENTRIES  (ENTRIES),
    .CTR_WIDTH(CTR_WIDTH),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk  (clk),
    .raddr(lookup_idx),
    .rdata(rdata),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BP_INIT;
      sweep_idx <= '0;
    end else if (state == BP_INIT) begin
      sweep_idx <= sweep_idx + IDX_W'(1);
      if (sweep_idx == IDX_W'(ENTRIES - 1)) state <= BP_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         x_valid <= 1'b0;
    else if (flush)  x_valid <= 1'b0;
    else if (!stall) x_valid <= if_is_br & ready;
  end

  // x_ctr forwards a same-cycle update so back-to-back training of one entry stays exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_idx  <= '0;
      x_pred <= 1'b0;
      x_ctr  <= '0;
    end else if (!stall) begin
      x_idx  <= lookup_idx;
      x_pred <= br_pred_taken;
      x_ctr  <= (upd && (x_idx == lookup_idx)) ? ctr_next : rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (x_pred != x_br_taken) stat_mispred <= stat_mispred + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomised + directed bench for branch_predictor_bht against a table-of-ints model.
module tb_branch_predictor_bht;

  localparam int PC_WIDTH  = 32;
  localparam int ENTRIES   = 32;
  localparam int CTR_WIDTH = 2;
  localparam int GHR_WIDTH = 5;
  localparam int CTR_MAX   = (1 << CTR_WIDTH) - 1;
  localparam int CTR_INI   = (1 << (CTR_WIDTH - 1)) - 1;
  localparam int THRESH    = 1 << (CTR_WIDTH - 1);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                stall = 1'b0;
  logic                flush = 1'b0;
  logic [PC_WIDTH-1:0] if_pc = '0;
  logic                if_is_br = 1'b0;
  logic                br_pred_taken;
  logic                x_br_taken = 1'b0;
  logic                ready;
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispred;

  branch_predictor_bht #(
    .PC_WIDTH (PC_WIDTH),
    .ENTRIES  (ENTRIES),
    .CTR_WIDTH(CTR_WIDTH),
    .GHR_WIDTH(GHR_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .if_pc        (if_pc),
    .if_is_br     (if_is_br),
    .br_pred_taken(br_pred_taken),
    .x_br_taken   (x_br_taken),
    .ready        (ready),
    .stat_branches(stat_branches),
    .stat_mispred (stat_mispred)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: predictor state in plain integers.
  int          m_tbl [ENTRIES];
  bit          m_init = 1'b1;
  int          m_sweep = 0;
  bit          m_valid = 1'b0;
  int          m_idx = 0;
  bit          m_pred = 1'b0;
  int unsigned m_br = 0;
  int unsigned m_mp = 0;
  int          m_ghr = 0;
  bit          model_on = 1'b0;
  int          mi_li;
  bit          mi_lp;
  bit          mi_rdy;

  function automatic int m_lookup_idx(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % ENTRIES);
`ifdef BHT_GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    return idx;
  endfunction

  function automatic bit m_predict();
    return !m_init && if_is_br && (m_tbl[m_lookup_idx(if_pc)] >= THRESH);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_sweep = 0; m_valid = 1'b0;
      m_br = 0; m_mp = 0; m_ghr = 0;
    end else begin
      mi_rdy = !m_init;
      mi_li  = m_lookup_idx(if_pc);
      mi_lp  = m_predict();
      if (m_init) begin
        m_tbl[m_sweep] = CTR_INI;
        if (m_sweep == ENTRIES - 1) m_init = 1'b0;
        m_sweep++;
      end else if (m_valid && !stall) begin
        m_br++;
        if (m_pred != x_br_taken) m_mp++;
        if (x_br_taken) m_tbl[m_idx] = (m_tbl[m_idx] == CTR_MAX) ? CTR_MAX : m_tbl[m_idx] + 1;
        else            m_tbl[m_idx] = (m_tbl[m_idx] == 0) ? 0 : m_tbl[m_idx] - 1;
        m_ghr = ((m_ghr << 1) | int'(x_br_taken)) % (1 << GHR_WIDTH);
      end
      if (flush) m_valid = 1'b0;
      else if (!stall) begin
        m_valid = if_is_br && mi_rdy;
        m_idx   = mi_li;
        m_pred  = mi_lp;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("ready", 32'(ready), 32'(!m_init));
      check("pred", 32'(br_pred_taken), 32'(m_predict()));
      check("stat_branches", stat_branches, m_br);
      check("stat_mispred", stat_mispred, m_mp);
    end
  end

  task automatic set_in(input logic r, input logic s, input logic f,
                        input logic [31:0] pc, input logic br, input logic tk);
    rst = r; stall = s; flush = f; if_pc = pc; if_is_br = br; x_br_taken = tk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned exp_br = 0;

  // Lookup in one cycle, resolve in the next, so the following lookup sees the update.
  task automatic do_branch(input logic [31:0] pc, input logic tk, output bit pred);
    set_in(1'b0, 1'b0, 1'b0, pc, 1'b1, tk);
    #1 pred = br_pred_taken;
    step();
    set_in(1'b0, 1'b0, 1'b0, pc, 1'b0, tk);
    step();
    exp_br++;
  endtask

  // rst has just been released: ready low for ENTRIES cycles, every lookup predicts 0.
  task automatic wait_ready();
    for (int c = 0; c < ENTRIES; c++) begin
      set_in(1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b1);
      #1;
      check("ready_low_in_sweep", 32'(ready), 32'd0);
      if (c % 8 == 3) check("pred_zero_in_sweep", 32'(br_pred_taken), 32'd0);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1 check("ready_after_sweep", 32'(ready), 32'd1);
    exp_br = 0;
  endtask

  bit p;

  initial begin
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    model_on = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1 check("reset_branches", stat_branches, 32'd0);
    check("reset_mispred", stat_mispred, 32'd0);
    wait_ready();

`ifndef BHT_GSHARE_EN
    do_branch(32'h100, 1'b1, p); check("pc100_pred1", 32'(p), 32'd0);
    do_branch(32'h100, 1'b1, p); check("pc100_pred2", 32'(p), 32'd1);
    #1 check("pc100_branches", stat_branches, 32'd2);
    check("pc100_mispred", stat_mispred, 32'd1);
    do_branch(32'h100, 1'b1, p); check("pc100_pred3", 32'(p), 32'd1);

    for (int i = 0; i < 10; i++) do_branch(32'h40, 1'b1, p);
    do_branch(32'h40, 1'b0, p); check("pc40_sat_taken", 32'(p), 32'd1);
    do_branch(32'h40, 1'b0, p); check("pc40_after_1_nt", 32'(p), 32'd1);
    do_branch(32'h40, 1'b0, p); check("pc40_after_2_nt", 32'(p), 32'd0);

    set_in(1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1);
      #1 check("stall_hold", stat_branches, exp_br);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 1'b1);
    step();
    #1 check("stall_release_once", stat_branches, exp_br + 1);
    step();
    #1 check("stall_no_double", stat_branches, exp_br + 1);
    exp_br++;

    set_in(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h300, 1'b0, 1'b1);
    step();
    #1 check("flush_no_update", stat_branches, exp_br);

    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    wait_ready();
    check("restart_branches", stat_branches, 32'd0);
    check("restart_mispred", stat_mispred, 32'd0);

    do_branch(32'h000, 1'b1, p); check("alias_train", 32'(p), 32'd0);
    do_branch(32'h080, 1'b1, p); check("alias_080", 32'(p), 32'd1);
    do_branch(32'h004, 1'b0, p); check("alias_004", 32'(p), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      do_branch(32'h100, (i % 2) == 0, p);
      if (i == 3) check("ghr_after_4", 32'(dut.ghr), 32'b01010);
      if (i >= 12) check("gshare_converged", 32'(p), 32'((i % 2) == 0));
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 499) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) == 0, $urandom,
             $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
      step();
    end

    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
